// File: rtl/modulation_sequencer.sv
// Sequences one modulation sample through a shared fixed-latency multiplier for all DEPTH transducers.
// Optional run-length counter (output run_cycles) is enabled by defining MODULATION_SEQUENCER_CYCLE_CNT_EN.
module modulation_sequencer #(
    parameter int DEPTH   = 249,
    parameter int LATENCY = 3,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       m,
    input  logic             gnt,
    output logic             mul_valid,
    output logic [IDX_W-1:0] mul_idx,
    output logic [7:0]       mul_m,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_idx,
    output logic             busy,
    output logic             done,
    output logic             overrun,
`ifdef MODULATION_SEQUENCER_CYCLE_CNT_EN
    output logic [15:0]      run_cycles,
`endif
    output logic [1:0]       state_dbg
);

    // Issue handshake: an index transfers to the multiplier in every cycle where mul_valid
    // is high. mul_valid is gnt qualified by the ISSUE state, so gnt acts as the ready.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t             state;
    logic [IDX_W-1:0]   cnt;
    logic               pend_v;
    logic [7:0]         pend_m;
    logic [LATENCY-1:0] dl_v;
    logic [IDX_W-1:0]   dl_idx [LATENCY];
    logic               last_wr;

    assign mul_valid = (state == ISSUE) && gnt;
    assign mul_idx   = cnt;
    assign wr_en     = dl_v[LATENCY-1];
    assign wr_idx    = dl_idx[LATENCY-1];
    assign state_dbg = state;
    assign last_wr   = wr_en && (wr_idx == LAST);

    // Delay line mirrors the multiplier pipeline so writes line up with results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_v <= '0;
            for (int i = 0; i < LATENCY; i++) dl_idx[i] <= '0;
        end else begin
            dl_v[0]   <= mul_valid;
            dl_idx[0] <= mul_idx;
            for (int i = 1; i < LATENCY; i++) begin
                dl_v[i]   <= dl_v[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mul_m   <= '0;
            pend_v  <= 1'b0;
            pend_m  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= start && (state != IDLE) && pend_v;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        cnt   <= '0;
                        mul_m <= m;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (gnt) begin
                        if (cnt == LAST) begin
                            state <= DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (last_wr) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    // A START arriving in this cycle is the newest pending value.
                    cnt <= '0;
                    if (start || pend_v) begin
                        state <= ISSUE;
                        mul_m <= start ? m : pend_m;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state == FIN) begin
                pend_v <= 1'b0;
            end else if (start && (state != IDLE)) begin
                pend_v <= 1'b1;
                pend_m <= m;
            end
        end
    end

`ifdef MODULATION_SEQUENCER_CYCLE_CNT_EN
    logic [15:0] cyc;

    // cyc restarts on every run start; the captured value includes the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc        <= '0;
            run_cycles <= '0;
        end else begin
            if (state == IDLE || state == FIN) begin
                cyc <= '0;
            end else if (cyc != 16'hFFFF) begin
                cyc <= cyc + 16'd1;
            end
            if (state == DRAIN && last_wr) begin
                run_cycles <= (cyc == 16'hFFFF) ? cyc : cyc + 16'd1;
            end
        end
    end
`endif

endmodule
